hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard controller: consumes the fields the ID/EX pipeline register presents to the EX stage, plus the source registers of the instruction currently in ID. It drives the stall, flush and PC-redirect controls back into PC, IF/ID and ID/EX. It sits between the decode stage and the EX stage and is the sole owner of pipeline freeze/bubble decisions.

## Interface
- FLUSH_CYC, 1: number of cycles IF/ID and ID/EX are flushed after a redirect (1..7).
- MMIO_TIMEOUT, 255: maximum cycles spent waiting on mmio_ready before forced release (1..255).
- ADDR_W, 14: PC/target width.

- clk  in  1  system clock; all state on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- id_rs1, id_rs2  in  5 each  source registers of the instruction in ID.
- id_use_rs1, id_use_rs2  in  1 each  instruction in ID actually reads that source.
- ex_rd  in  5  destination of the instruction in EX.
- ex_reg_write  in  1  EX instruction writes ex_rd.
- ex_mem_read  in  1  EX instruction is a load.
- ex_branch, ex_j, ex_jalr  in  1 each  EX instruction is a conditional branch / jal / jalr.
- ex_taken  in  1  branch compare result for EX instruction.
- ex_target  in  ADDR_W  resolved target address.
- ex_mmio_req  in  1  EX instruction accesses a peripheral.
- mmio_ready  in  1  peripheral completes the access.
- pc_stall, ifid_stall, idex_stall  out  1 each  hold the register.
- ifid_flush, idex_flush  out  1 each  load a bubble: RegWrite, Branch, J, Jalr, and mem controls cleared.
- pc_redirect  out  1  load pc_target into PC.
- pc_target  out  ADDR_W  redirect address.
- mmio_timeout  out  1  one-cycle pulse on forced MMIO release.
- stall_count  out  16  saturating count of cycles with pc_stall=1.

## Operation
- FSM states: RUN, LOAD_BUBBLE, REDIRECT, MMIO_WAIT. Registered state; control outputs are combinational from state and inputs.
- The following conditions are evaluated in RUN only. Priority is redirect > mmio > load-use.
- Redirect: (ex_branch & ex_taken) | ex_j | ex_jalr.
  - Outputs: pc_redirect=1, pc_target=ex_target, ifid_flush=1, idex_flush=1.
  - If FLUSH_CYC>1, go to REDIRECT with flush_cnt=FLUSH_CYC-1. Otherwise stay in RUN.
- REDIRECT: ifid_flush=idex_flush=1, pc_redirect=0. Decrement flush_cnt each cycle; at flush_cnt==1 return to RUN.
- MMIO wait: ex_mmio_req & !mmio_ready.
  - Outputs: pc_stall=ifid_stall=idex_stall=1. Go to MMIO_WAIT with wait_cnt=1.
  - ex_mmio_req & mmio_ready in the same cycle causes no stall.
- MMIO_WAIT: all three stalls held.
  - On mmio_ready: stalls drop in that same cycle; return to RUN.
  - On wait_cnt==MMIO_TIMEOUT with no mmio_ready: mmio_timeout=1 and stalls drop for one cycle; return to RUN. Otherwise wait_cnt++.
- Load-use: ex_mem_read & ex_reg_write & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
  - Outputs: pc_stall=ifid_stall=1, idex_flush=1. Go to LOAD_BUBBLE.
- LOAD_BUBBLE: no outputs asserted; unconditionally return to RUN next cycle. The bubble in EX prevents re-detection.
- Register x0 never causes a hazard.
- stall_count increments on every cycle with pc_stall=1 and saturates at 16'hFFFF.

## Timing
- Reset:
  - State RUN; flush_cnt, wait_cnt, stall_count = 0.
  - While rst_n=0, every output is forced to 0, including pc_target=0.
- Decision latency is 0 cycles: controls are valid in the same cycle the EX/ID fields are valid, before the next posedge.
- Load-use costs exactly 1 bubble. Redirect costs FLUSH_CYC flushed cycles. An MMIO stall of N cycles means mmio_ready arrived N cycles after the request.
- Reset asserted mid-REDIRECT or mid-MMIO_WAIT: the FSM returns to RUN immediately and counters clear. No timeout pulse is emitted.
- A redirect detected while a load-use condition also holds: only the redirect takes effect. The flushed instruction in ID is discarded.
- Stall and flush on the same register in the same cycle is never produced.

## Structure
- Shared package/header pipe_pkg holds:
  - the state encodings (HZ_RUN=2'd0, HZ_LOAD=2'd1, HZ_REDIR=2'd2, HZ_MMIO=2'd3);
  - ADDR_W;
  - the bubble control values reused by IF/ID and ID/EX.
- One sub-module, hazard_detect: purely combinational; computes the redirect, mmio_block and load_use flags. It is instanced once inside hazard_ctrl.

## Test plan
- Load-use: ex_mem_read=1, ex_reg_write=1, ex_rd=5, id_rs2=5, id_use_rs2=1 -> exactly one cycle of pc_stall=ifid_stall=idex_flush=1; stall_count=1; same inputs with ex_rd=0 -> no stall.
- Taken branch, FLUSH_CYC=2: ex_branch=1, ex_taken=1, ex_target=14'h0040 -> pc_redirect=1 with pc_target=0x0040 for 1 cycle; ifid_flush/idex_flush high for 2 cycles; ex_taken=0 -> nothing asserted.
- MMIO: ex_mmio_req=1, mmio_ready rises 3 cycles later -> stalls high exactly 3 cycles; stall_count=3.
- Timeout, MMIO_TIMEOUT=4, mmio_ready never rises -> stalls for 4 cycles, then a single mmio_timeout pulse, then RUN.
- Priority: jal plus load-use plus mmio request in the same cycle -> only the redirect path is asserted; no stall.
- Reset mid-MMIO_WAIT (rst_n low for 1 cycle) -> all outputs 0 asynchronously; FSM in RUN; stall_count=0 after release.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline control definitions: hazard FSM encodings, PC width and
// the control values that make up a bubble in IF/ID and ID/EX.
package pipe_pkg;

    localparam int ADDR_W = 14;

    typedef enum logic [1:0] {
        HZ_RUN   = 2'd0,
        HZ_LOAD  = 2'd1,
        HZ_REDIR = 2'd2,
        HZ_MMIO  = 2'd3
    } hz_state_t;

    typedef struct packed {
        logic reg_write;
        logic branch;
        logic j;
        logic jalr;
        logic mem_read;
        logic mem_write;
    } pipe_ctrl_t;

    // A flushed stage carries no side effects: nothing written, no control transfer, no memory access.
    localparam pipe_ctrl_t BUBBLE_CTRL = '0;

    function automatic logic reg_hit(input logic [4:0] src, input logic use_src,
                                     input logic [4:0] rd);
        return use_src && (src == rd) && (rd != 5'd0);
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational hazard flags derived from the EX fields and the ID sources.
module hazard_detect
    import pipe_pkg::*;
(
    input  logic       ex_branch,
    input  logic       ex_j,
    input  logic       ex_jalr,
    input  logic       ex_taken,
    input  logic       ex_mmio_req,
    input  logic       mmio_ready,
    input  logic       ex_mem_read,
    input  logic       ex_reg_write,
    input  logic [4:0] ex_rd,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_use_rs1,
    input  logic       id_use_rs2,
    output logic       redirect,
    output logic       mmio_block,
    output logic       load_use
);

    assign redirect   = (ex_branch && ex_taken) || ex_j || ex_jalr;
    assign mmio_block = ex_mmio_req && !mmio_ready;
    // x0 is filtered inside reg_hit so a load to x0 never stalls.
    assign load_use   = ex_mem_read && ex_reg_write &&
                        (reg_hit(id_rs1, id_use_rs1, ex_rd) || reg_hit(id_rs2, id_use_rs2, ex_rd));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: owns stall, flush and PC-redirect decisions
// for PC, IF/ID and ID/EX. Controls are combinational from state and inputs.
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int FLUSH_CYC    = 1,
    parameter int MMIO_TIMEOUT = 255,
    parameter int ADDR_W       = pipe_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [4:0]        ex_rd,
    input  logic              ex_reg_write,
    input  logic              ex_mem_read,
    input  logic              ex_branch,
    input  logic              ex_j,
    input  logic              ex_jalr,
    input  logic              ex_taken,
    input  logic [ADDR_W-1:0] ex_target,
    input  logic              ex_mmio_req,
    input  logic              mmio_ready,
    output logic              pc_stall,
    output logic              ifid_stall,
    output logic              idex_stall,
    output logic              ifid_flush,
    output logic              idex_flush,
    output logic              pc_redirect,
    output logic [ADDR_W-1:0] pc_target,
    output logic              mmio_timeout,
    output logic [15:0]       stall_count
);

    hz_state_t  state;
    logic [2:0] flush_cnt;
    logic [7:0] wait_cnt;
    logic       redirect;
    logic       mmio_block;
    logic       load_use;
    logic       wait_expired;

    hazard_detect u_detect (
        .ex_branch    (ex_branch),
        .ex_j         (ex_j),
        .ex_jalr      (ex_jalr),
        .ex_taken     (ex_taken),
        .ex_mmio_req  (ex_mmio_req),
        .mmio_ready   (mmio_ready),
        .ex_mem_read  (ex_mem_read),
        .ex_reg_write (ex_reg_write),
        .ex_rd        (ex_rd),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_use_rs1   (id_use_rs1),
        .id_use_rs2   (id_use_rs2),
        .redirect     (redirect),
        .mmio_block   (mmio_block),
        .load_use     (load_use)
    );

    assign wait_expired = (wait_cnt == 8'(MMIO_TIMEOUT));

    // Outputs are gated by rst_n directly so they drop without waiting for a clock edge.
    always_comb begin
        pc_stall     = 1'b0;
        ifid_stall   = 1'b0;
        idex_stall   = 1'b0;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        pc_redirect  = 1'b0;
        pc_target    = '0;
        mmio_timeout = 1'b0;
        if (rst_n) begin
            case (state)
                HZ_RUN: begin
                    if (redirect) begin
                        pc_redirect = 1'b1;
                        pc_target   = ex_target;
                        ifid_flush  = 1'b1;
                        idex_flush  = 1'b1;
                    end else if (mmio_block) begin
                        pc_stall   = 1'b1;
                        ifid_stall = 1'b1;
                        idex_stall = 1'b1;
                    end else if (load_use) begin
                        pc_stall   = 1'b1;
                        ifid_stall = 1'b1;
                        idex_flush = 1'b1;
                    end
                end
                HZ_REDIR: begin
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end
                HZ_MMIO: begin
                    if (!mmio_ready) begin
                        if (wait_expired) begin
                            mmio_timeout = 1'b1;
                        end else begin
                            pc_stall   = 1'b1;
                            ifid_stall = 1'b1;
                            idex_stall = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= HZ_RUN;
            flush_cnt   <= '0;
            wait_cnt    <= '0;
            stall_count <= '0;
        end else begin
            if (pc_stall && stall_count != 16'hFFFF) begin
                stall_count <= stall_count + 16'd1;
            end
            case (state)
                HZ_RUN: begin
                    if (redirect) begin
                        if (FLUSH_CYC > 1) begin
                            state     <= HZ_REDIR;
                            flush_cnt <= 3'(FLUSH_CYC - 1);
                        end
                    end else if (mmio_block) begin
                        state    <= HZ_MMIO;
                        wait_cnt <= 8'd1;
                    end else if (load_use) begin
                        state <= HZ_LOAD;
                    end
                end
                HZ_LOAD: state <= HZ_RUN;
                HZ_REDIR: begin
                    if (flush_cnt <= 3'd1) begin
                        state     <= HZ_RUN;
                        flush_cnt <= '0;
                    end else begin
                        flush_cnt <= flush_cnt - 3'd1;
                    end
                end
                HZ_MMIO: begin
                    if (mmio_ready || wait_expired) begin
                        state    <= HZ_RUN;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: state <= HZ_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed vectors push expected controls,
// a monitor pops and compares each cycle on the falling edge.
module tb_hazard_ctrl;

    localparam int AW = 14;

    // Expected control flag layout: {pc_stall, ifid_stall, idex_stall, ifid_flush, idex_flush, pc_redirect, mmio_timeout}
    localparam logic [6:0] F_NONE = 7'b0000000;
    localparam logic [6:0] F_LU   = 7'b1100100;
    localparam logic [6:0] F_MM   = 7'b1110000;
    localparam logic [6:0] F_RD   = 7'b0001110;
    localparam logic [6:0] F_FL   = 7'b0001100;
    localparam logic [6:0] F_TO   = 7'b0000001;

    typedef struct packed {
        logic [6:0]    flags;
        logic [AW-1:0] target;
        logic [15:0]   sc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [4:0]    id_rs1, id_rs2, ex_rd;
    logic          id_use_rs1, id_use_rs2, ex_reg_write, ex_mem_read;
    logic          ex_branch, ex_j, ex_jalr, ex_taken, ex_mmio_req, mmio_ready;
    logic [AW-1:0] ex_target;
    logic          pc_stall, ifid_stall, idex_stall, ifid_flush, idex_flush;
    logic          pc_redirect, mmio_timeout;
    logic [AW-1:0] pc_target;
    logic [15:0]   stall_count;

    exp_t        sb[$];
    int          checks = 0;
    int          passed = 0;
    logic [15:0] exp_sc = 16'd0;

    hazard_ctrl #(.FLUSH_CYC(2), .MMIO_TIMEOUT(4), .ADDR_W(AW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_use_rs1   (id_use_rs1),
        .id_use_rs2   (id_use_rs2),
        .ex_rd        (ex_rd),
        .ex_reg_write (ex_reg_write),
        .ex_mem_read  (ex_mem_read),
        .ex_branch    (ex_branch),
        .ex_j         (ex_j),
        .ex_jalr      (ex_jalr),
        .ex_taken     (ex_taken),
        .ex_target    (ex_target),
        .ex_mmio_req  (ex_mmio_req),
        .mmio_ready   (mmio_ready),
        .pc_stall     (pc_stall),
        .ifid_stall   (ifid_stall),
        .idex_stall   (idex_stall),
        .ifid_flush   (ifid_flush),
        .idex_flush   (idex_flush),
        .pc_redirect  (pc_redirect),
        .pc_target    (pc_target),
        .mmio_timeout (mmio_timeout),
        .stall_count  (stall_count)
    );

    always #5 clk = ~clk;

    task automatic clr();
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        ex_rd = 5'd0; ex_reg_write = 1'b0; ex_mem_read = 1'b0;
        ex_branch = 1'b0; ex_j = 1'b0; ex_jalr = 1'b0; ex_taken = 1'b0;
        ex_target = '0; ex_mmio_req = 1'b0; mmio_ready = 1'b0;
    endtask

    task automatic load_use_rs2(input logic [4:0] rd);
        ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = rd;
        id_rs2 = rd; id_use_rs2 = 1'b1;
    endtask

    // Push expectation for the current cycle, then advance to just after the next rising edge.
    task automatic cyc(input logic [6:0] flags, input logic [AW-1:0] tgt);
        exp_t e;
        if (!rst_n) exp_sc = 16'd0;
        e.flags  = flags;
        e.target = tgt;
        e.sc     = exp_sc;
        sb.push_back(e);
        if (flags[6] && rst_n && exp_sc != 16'hFFFF) exp_sc = exp_sc + 16'd1;
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        exp_t       e;
        logic [6:0] got;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e   = sb.pop_front();
                got = {pc_stall, ifid_stall, idex_stall, ifid_flush, idex_flush, pc_redirect, mmio_timeout};
                checks++;
                if (got === e.flags && pc_target === e.target) passed++;
                else $display("FAIL ctrl t=%0t got flags=%b target=%h required flags=%b target=%h",
                              $time, got, pc_target, e.flags, e.target);
                checks++;
                if (stall_count === e.sc) passed++;
                else $display("FAIL stall_count t=%0t got %0d required %0d", $time, stall_count, e.sc);
            end
        end
    end

    initial begin : stimulus
        rst_n = 1'b0;
        clr();
        @(posedge clk);
        #1;
        // Held in reset with a load-use pattern present: everything stays low.
        load_use_rs2(5'd5);
        cyc(F_NONE, '0);
        clr();
        rst_n = 1'b1;
        cyc(F_NONE, '0);

        // Load-use on rs2: one bubble, then LOAD_BUBBLE, then RUN.
        load_use_rs2(5'd5);
        cyc(F_LU, '0);
        cyc(F_NONE, '0);
        clr();
        cyc(F_NONE, '0);
        // Same pattern against x0 never stalls.
        load_use_rs2(5'd0);
        cyc(F_NONE, '0);
        // rs1 match, then the same rs1 match without id_use_rs1.
        clr();
        ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; id_use_rs1 = 1'b1;
        cyc(F_LU, '0);
        cyc(F_NONE, '0);
        id_use_rs1 = 1'b0;
        cyc(F_NONE, '0);

        // Taken branch: one redirect cycle plus one extra flush cycle.
        clr();
        ex_branch = 1'b1; ex_taken = 1'b1; ex_target = 14'h0040;
        cyc(F_RD, 14'h0040);
        clr();
        cyc(F_FL, '0);
        cyc(F_NONE, '0);
        ex_branch = 1'b1; ex_taken = 1'b0; ex_target = 14'h0040;
        cyc(F_NONE, '0);
        clr();
        ex_jalr = 1'b1; ex_target = 14'h3FFF;
        cyc(F_RD, 14'h3FFF);
        clr();
        cyc(F_FL, '0);

        // MMIO: ready arrives 3 cycles after the request.
        ex_mmio_req = 1'b1;
        cyc(F_MM, '0);
        cyc(F_MM, '0);
        cyc(F_MM, '0);
        mmio_ready = 1'b1;
        cyc(F_NONE, '0);
        clr();
        cyc(F_NONE, '0);
        ex_mmio_req = 1'b1; mmio_ready = 1'b1;
        cyc(F_NONE, '0);

        // Timeout: four stalled cycles, then a single release pulse.
        clr();
        ex_mmio_req = 1'b1;
        cyc(F_MM, '0);
        cyc(F_MM, '0);
        cyc(F_MM, '0);
        cyc(F_MM, '0);
        cyc(F_TO, '0);
        clr();
        cyc(F_NONE, '0);

        // jal with load-use and a blocked MMIO request: redirect alone wins.
        load_use_rs2(5'd9);
        ex_j = 1'b1; ex_target = 14'h0123; ex_mmio_req = 1'b1;
        cyc(F_RD, 14'h0123);
        clr();
        cyc(F_FL, '0);
        cyc(F_NONE, '0);

        // Reset pulse in the middle of an MMIO wait.
        ex_mmio_req = 1'b1;
        cyc(F_MM, '0);
        cyc(F_MM, '0);
        rst_n = 1'b0;
        cyc(F_NONE, '0);
        rst_n = 1'b1;
        clr();
        cyc(F_NONE, '0);
        // A fresh load-use stall shows the FSM is back in RUN.
        load_use_rs2(5'd12);
        cyc(F_LU, '0);
        clr();
        cyc(F_NONE, '0);

        repeat (4) @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            $display("FAIL drain pending=%0d required 0", sb.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
